// File: rtl/curve_lut_writer.sv
// curve_lut_writer: builds a 256-entry piecewise-linear contrast curve into the idle bank of a ping-pong LUT.
// Define CURVE_WR_VSYNC_SWAP_EN to hold the bank swap until a frame_vsync rising edge.
module curve_lut_writer #(
  parameter int LUT_AW    = 8,
  parameter int GAIN_FRAC = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cfg_start,
  input  logic [7:0]      cfg_thresh,
  input  logic [7:0]      cfg_gain_lo,
  input  logic [7:0]      cfg_gain_hi,
  input  logic            frame_vsync,
  output logic            lut_we,
  output logic [LUT_AW:0] lut_waddr,
  output logic [7:0]      lut_wdata,
  output logic            rd_bank,
  output logic            busy,
  output logic            done
);
  typedef enum logic [1:0] {IDLE, CALC, DRAIN, WAIT_SWAP} state_e;
  state_e state_q, state_d;
  logic [7:0] thr_q, glo_q, ghi_q;
  logic [LUT_AW-1:0] x_q, s1_x_q;
  logic drain_q, done_q, rd_bank_q;
  logic s1_v_q, s1_hi_q;
  logic [7:0] s1_d_q;
  logic we_q;
  logic [LUT_AW:0] waddr_q;
  logic [7:0] wdata_q;
  logic take, issue, swap, swap_now;
  logic [15:0] prod;
  logic [12:0] ofs, sum;
  logic [7:0] y_sat;
`ifdef CURVE_WR_VSYNC_SWAP_EN
  logic vsync_q;
  always_ff @(posedge clk) vsync_q <= rst ? 1'b0 : frame_vsync;
  assign swap = frame_vsync & ~vsync_q;
`else
  // Without vsync gating the swap is released one settle cycle into WAIT_SWAP.
  logic settle_q, unused_vsync;
  always_ff @(posedge clk) settle_q <= !rst && state_q == WAIT_SWAP;
  assign swap = settle_q;
  assign unused_vsync = frame_vsync;
`endif
  always_ff @(posedge clk) state_q <= rst ? IDLE : state_d;
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      state_d = take ? CALC : IDLE;
      CALC:      state_d = &x_q ? DRAIN : CALC;
      DRAIN:     state_d = drain_q ? WAIT_SWAP : DRAIN;
      WAIT_SWAP: state_d = swap ? IDLE : WAIT_SWAP;
      default:   state_d = IDLE;
    endcase
  end
  // A start landing on the done cycle is dropped so builds never overlap the swap.
  always_comb begin
    take     = state_q == IDLE && cfg_start && !done_q;
    issue    = state_q == CALC;
    swap_now = state_q == WAIT_SWAP && swap;
    busy     = state_q != IDLE || done_q;
  end
  always_comb begin
    prod  = 16'(s1_d_q) * 16'(s1_hi_q ? ghi_q : glo_q);
    ofs   = 13'(prod >> GAIN_FRAC);
    sum   = s1_hi_q ? 13'(thr_q) + ofs : 13'(thr_q) - ofs;
    y_sat = sum[12] ? 8'h00 : |sum[11:8] ? 8'hFF : sum[7:0];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      thr_q     <= '0;
      glo_q     <= '0;
      ghi_q     <= '0;
      x_q       <= '0;
      drain_q   <= 1'b0;
      s1_v_q    <= 1'b0;
      s1_hi_q   <= 1'b0;
      s1_d_q    <= '0;
      s1_x_q    <= '0;
      we_q      <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      rd_bank_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      if (take) begin
        thr_q <= cfg_thresh;
        glo_q <= cfg_gain_lo;
        ghi_q <= cfg_gain_hi;
        x_q   <= '0;
      end else if (issue) begin
        x_q <= x_q + 1'b1;
      end
      drain_q <= state_q == DRAIN && !drain_q;
      s1_v_q  <= issue;
      s1_hi_q <= 8'(x_q) > thr_q;
      s1_d_q  <= 8'(x_q) > thr_q ? 8'(x_q) - thr_q : thr_q - 8'(x_q);
      s1_x_q  <= x_q;
      we_q    <= s1_v_q;
      if (s1_v_q) begin
        waddr_q <= {~rd_bank_q, s1_x_q};
        wdata_q <= y_sat;
      end
      rd_bank_q <= rd_bank_q ^ swap_now;
      done_q    <= swap_now;
    end
  end
  assign lut_we    = we_q;
  assign lut_waddr = waddr_q;
  assign lut_wdata = wdata_q;
  assign rd_bank   = rd_bank_q;
  assign done      = done_q;
endmodule

// File: tb/tb_curve_lut_writer.sv
// tb_curve_lut_writer: directed builds checked cycle-by-cycle against a plain-arithmetic curve model.
module tb_curve_lut_writer;
  logic clk = 1'b0, rst = 1'b1, cfg_start = 1'b0, frame_vsync = 1'b0;
  logic [7:0] cfg_thresh = '0, cfg_gain_lo = '0, cfg_gain_hi = '0;
  logic lut_we, rd_bank, busy, done;
  logic [8:0] lut_waddr;
  logic [7:0] lut_wdata;
  curve_lut_writer dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_thresh(cfg_thresh),
    .cfg_gain_lo(cfg_gain_lo), .cfg_gain_hi(cfg_gain_hi), .frame_vsync(frame_vsync),
    .lut_we(lut_we), .lut_waddr(lut_waddr), .lut_wdata(lut_wdata),
    .rd_bank(rd_bank), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int checks = 0, errors = 0;
  int c0 = 0, swap_c = -1, done_rel = -1, wr_cnt = 0, first_w = -1, last_w = -1;
  int m_t = 0, m_lo = 0, m_hi = 0;
  bit bld = 0, m_bank = 0, chk_en = 0, prev_vs = 0;
  logic [7:0] mem [512];
`ifdef CURVE_WR_VSYNC_SWAP_EN
  localparam bit VS_MODE = 1'b1;
`else
  localparam bit VS_MODE = 1'b0;
`endif
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask
  function automatic int curve(input int x, input int t, input int lo, input int hi);
    int y;
    y = (x <= t) ? t - ((t - x) * lo) / 16 : t + ((x - t) * hi) / 16;
    return y < 0 ? 0 : (y > 255 ? 255 : y);
  endfunction
  always @(negedge clk) begin
    int rel;
    bit ew;
    if (chk_en) begin
      rel = cyc - c0;
      if (VS_MODE && bld && swap_c < 0 && rel >= 259 && frame_vsync && !prev_vs) swap_c = cyc + 1;
      ew = bld && rel >= 3 && rel <= 258;
      chk("we", int'(lut_we), int'(ew));
      if (ew) begin
        chk("waddr", int'(lut_waddr), (m_bank ? 0 : 256) + rel - 3);
        chk("wdata", int'(lut_wdata), curve(rel - 3, m_t, m_lo, m_hi));
      end
      chk("busy", int'(busy), int'(bld && rel >= 1 && (swap_c < 0 || cyc <= swap_c)));
      chk("done", int'(done), int'(bld && cyc == swap_c));
      if (bld && cyc == swap_c) begin
        m_bank = ~m_bank;
        done_rel = rel;
        bld = 0;
      end
      chk("rd_bank", int'(rd_bank), int'(m_bank));
      if (lut_we) begin
        wr_cnt++;
        mem[lut_waddr] = lut_wdata;
        if (first_w < 0) first_w = rel;
        last_w = rel;
      end
      if (rst) begin
        bld = 0;
        m_bank = 0;
      end
    end
    prev_vs = frame_vsync;
  end
  task automatic begin_build(input logic [7:0] t, input logic [7:0] lo, input logic [7:0] hi);
    @(posedge clk); #1;
    cfg_thresh = t; cfg_gain_lo = lo; cfg_gain_hi = hi; cfg_start = 1'b1;
    c0 = cyc; m_t = t; m_lo = lo; m_hi = hi; bld = 1;
    swap_c = VS_MODE ? -1 : cyc + 261;
    done_rel = -1; wr_cnt = 0; first_w = -1; last_w = -1;
  endtask
  task automatic run_build(input logic [7:0] t, input logic [7:0] lo, input logic [7:0] hi,
                           input int v1, input int v2, input bit poke);
    begin_build(t, lo, hi);
    for (int r = 1; r <= 450 && done_rel < 0; r++) begin
      @(posedge clk); #1;
      cfg_start = poke && (r == 40 || r == 41);
      if (poke && r == 40) begin
        cfg_thresh = 8'hFF; cfg_gain_lo = 8'hFF; cfg_gain_hi = 8'h01;
      end
      frame_vsync = (r == v1 || r == v2);
    end
    cfg_start = 1'b0;
    frame_vsync = 1'b0;
  endtask
  initial begin
    int bad;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("idle_rd_bank", int'(rd_bank), 0);
    chk("idle_we", int'(lut_we), 0);
    chk("idle_busy", int'(busy), 0);
    run_build(8'h7F, 8'h20, 8'h08, 100, 300, 0);
    chk("A_done_rel", done_rel, VS_MODE ? 301 : 261);
    chk("A_writes", wr_cnt, 256);
    chk("A_first", first_w, 3);
    chk("A_last", last_w, 258);
    chk("A_0", int'(mem[256]), 8'h00);
    chk("A_100", int'(mem[356]), 8'h49);
    chk("A_127", int'(mem[383]), 8'h7F);
    chk("A_200", int'(mem[456]), 8'hA3);
    chk("A_255", int'(mem[511]), 8'hBF);
    chk("A_bank", int'(rd_bank), 1);
    run_build(8'h00, 8'h00, 8'h30, 270, 0, 1);
    chk("B_done_rel", done_rel, VS_MODE ? 271 : 261);
    chk("B_writes", wr_cnt, 256);
    chk("B_0", int'(mem[0]), 8'h00);
    chk("B_1", int'(mem[1]), 8'h03);
    chk("B_85", int'(mem[85]), 8'hFF);
    chk("B_200", int'(mem[200]), 8'hFF);
    chk("B_bank", int'(rd_bank), 0);
    run_build(8'h80, 8'h00, 8'h00, 270, 0, 0);
    bad = 0;
    for (int i = 0; i < 256; i++) if (mem[256 + i] !== 8'h80) bad++;
    chk("C_flat", bad, 0);
    chk("C_writes", wr_cnt, 256);
    chk("C_bank", int'(rd_bank), 1);
    begin_build(8'h7F, 8'h20, 8'h08);
    for (int r = 1; r <= 150; r++) begin
      @(posedge clk); #1;
      cfg_start = 1'b0;
      rst = (r == 150);
    end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_we", int'(lut_we), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_rd_bank", int'(rd_bank), 0);
    run_build(8'h40, 8'h10, 8'h10, 270, 0, 0);
    chk("E_writes", wr_cnt, 256);
    chk("E_first", first_w, 3);
    chk("E_33", int'(mem[256 + 8'h33]), 8'h33);
    chk("E_255", int'(mem[511]), 8'hFF);
    chk("E_bank", int'(rd_bank), 1);
    repeat (5) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
